reg_scoreboard_decoded: RTL and testbench

//  Parametrised successor to the fixed 5-to-32 write decoder. Decodes register addresses to one-hot

---
 rtl/scoreboard_pkg.sv | 11 +
 rtl/decoder_onehot.sv | 25 ++
 rtl/reg_scoreboard_decoded.sv | 113 +++++++++++
 tb/tb_reg_scoreboard_decoded.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard.
// Default widths used by the scoreboard and regfile ports.
package scoreboard_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int NREGS_DEF  = 1 << ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [NREGS_DEF-1:0]  reg_mask_t;

endpackage

// File: rtl/decoder_onehot.sv
// Gate-level binary to one-hot decoder with enable.
// Each output is the AND of matching address literals.
module decoder_onehot #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]      in,
    input  logic                   en,
    output logic [(1<<ADDR_W)-1:0] out
);

    localparam int NOUT = 1 << ADDR_W;

    for (genvar i = 0; i < NOUT; i++) begin : g_out
        logic [ADDR_W-1:0] m;
        for (genvar b = 0; b < ADDR_W; b++) begin : g_bit
            if (((i >> b) & 1) == 1) begin : g_pos
                assign m[b] = in[b];
            end else begin : g_neg
                assign m[b] = ~in[b];
            end
        end
        assign out[i] = en & (&m);
    end

endmodule

// File: rtl/reg_scoreboard_decoded.sv
// Register busy scoreboard with RAW/WAW issue stall
// and a registered one-hot regfile write-enable bus.
module reg_scoreboard_decoded
    import scoreboard_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ZERO_REG  = 1,
    parameter int WB_BYPASS = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [ADDR_W-1:0]        iss_rd,
    input  logic                     iss_rd_en,
    input  logic [ADDR_W-1:0]        iss_rs1,
    input  logic                     iss_rs1_en,
    input  logic [ADDR_W-1:0]        iss_rs2,
    input  logic                     iss_rs2_en,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_rd,
    output logic [(1<<ADDR_W)-1:0]   wr_onehot,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          busy_count
);

    localparam int   NREGS = 1 << ADDR_W;
    localparam logic BYP   = (WB_BYPASS != 0);
    localparam logic KEEP0 = (ZERO_REG == 0);

    // Register 0 is masked out everywhere when it is hardwired.
    localparam logic [NREGS-1:0] ZMASK = {{(NREGS-1){1'b1}}, KEEP0};

    logic [NREGS-1:0] rd_oh;
    logic [NREGS-1:0] rs1_oh;
    logic [NREGS-1:0] rs2_oh;
    logic [NREGS-1:0] wb_oh;
    logic [NREGS-1:0] eb;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_q;
    logic [NREGS-1:0] wr_d;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  cnt_d;
    logic             h1;
    logic             h2;
    logic             hw;
    logic             accept;

    decoder_onehot #(.ADDR_W(ADDR_W)) u_dec_rd (
        .in (iss_rd),
        .en (iss_rd_en),
        .out(rd_oh)
    );

    decoder_onehot #(.ADDR_W(ADDR_W)) u_dec_rs1 (
        .in (iss_rs1),
        .en (iss_rs1_en),
        .out(rs1_oh)
    );

    decoder_onehot #(.ADDR_W(ADDR_W)) u_dec_rs2 (
        .in (iss_rs2),
        .en (iss_rs2_en),
        .out(rs2_oh)
    );

    decoder_onehot #(.ADDR_W(ADDR_W)) u_dec_wb (
        .in (wb_rd),
        .en (wb_valid),
        .out(wb_oh)
    );

    // A same-cycle writeback can hide a busy bit from the hazard check.
    assign eb = busy_q & ~(wb_oh & {NREGS{BYP}}) & ZMASK;

    assign h1 = |(rs1_oh & eb);
    assign h2 = |(rs2_oh & eb);
    assign hw = |(rd_oh & eb);

    assign iss_ready = ~(h1 | h2 | hw);
    assign accept    = iss_valid & iss_ready;

    // Writeback clears first, then an accepted issue sets.
    assign busy_d = ((busy_q & ~wb_oh) | (rd_oh & {NREGS{accept}})) & ZMASK;
    assign wr_d   = wb_oh & ZMASK;

    // Popcount of the next busy map, registered alongside it.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    // Scoreboard state and write-enable pipeline register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy       = busy_q;
    assign wr_onehot  = wr_q;
    assign busy_count = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard_decoded.sv
// Directed and randomized checks for the register scoreboard.
// Write enables are checked through an expected-value queue.
module tb_reg_scoreboard_decoded;
    import scoreboard_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        iv, ird_en, irs1_en, irs2_en, wv;
    logic [4:0]  ird, irs1, irs2, wrd;
    logic        rdy;
    reg_mask_t   wr, bsy;
    logic [5:0]  cnt;

    logic        iv3, ird_en3, irs1_en3, irs2_en3, wv3;
    logic [2:0]  ird3, irs13, irs23, wrd3;
    logic        rdy3;
    logic [7:0]  wr3, bsy3;
    logic [3:0]  cnt3;

    int unsigned total;
    int unsigned passed;
    reg_mask_t   wrq[$];
    logic [7:0]  wrq3[$];

    reg_scoreboard_decoded u_dut (
        .clock(clk), .reset_n(rst_n),
        .iss_valid(iv), .iss_ready(rdy),
        .iss_rd(ird), .iss_rd_en(ird_en),
        .iss_rs1(irs1), .iss_rs1_en(irs1_en),
        .iss_rs2(irs2), .iss_rs2_en(irs2_en),
        .wb_valid(wv), .wb_rd(wrd),
        .wr_onehot(wr), .busy(bsy), .busy_count(cnt)
    );

    reg_scoreboard_decoded #(.ADDR_W(3)) u_dut3 (
        .clock(clk), .reset_n(rst_n),
        .iss_valid(iv3), .iss_ready(rdy3),
        .iss_rd(ird3), .iss_rd_en(ird_en3),
        .iss_rs1(irs13), .iss_rs1_en(irs1_en3),
        .iss_rs2(irs23), .iss_rs2_en(irs2_en3),
        .wb_valid(wv3), .wb_rd(wrd3),
        .wr_onehot(wr3), .busy(bsy3), .busy_count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        iv = 0; ird_en = 0; irs1_en = 0; irs2_en = 0; wv = 0;
        ird = 0; irs1 = 0; irs2 = 0; wrd = 0;
    endtask

    // Push the expected write enable, clock once, pop and compare.
    task automatic cyc();
        reg_mask_t e;
        e = '0;
        if (wv && wrd != 0) e[wrd] = 1'b1;
        wrq.push_back(e);
        @(posedge clk);
        #1;
        chk("wr_onehot", wr, wrq.pop_front());
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        iv = 1; ird_en = 1; ird = rd;
    endtask

    logic [7:0] m3, eb3, rdoh, e3;
    logic       er3, acc3;

    initial begin
        total = 0; passed = 0;
        idle();
        iv3 = 0; ird_en3 = 0; irs1_en3 = 0; irs2_en3 = 0; wv3 = 0;
        ird3 = 0; irs13 = 0; irs23 = 0; wrd3 = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // 1. junk activity, then reset mid-cycle
        issue(5'd3); wv = 1; wrd = 5'd9;
        cyc();
        chk("junk_busy", bsy, 64'h8);
        #2 rst_n = 0;
        #1;
        chk("rst_busy", bsy, 0);
        chk("rst_wr", wr, 0);
        chk("rst_cnt", cnt, 0);
        idle();
        @(posedge clk);
        #1 rst_n = 1;
        wrq.delete();

        // 2. RAW stall and writeback bypass
        issue(5'd5);
        #1 chk("rdy_rd5", rdy, 1);
        cyc();
        chk("busy5", bsy, 64'h20);
        chk("cnt1", cnt, 1);
        idle(); iv = 1; irs1_en = 1; irs1 = 5'd5;
        #1 chk("raw_stall", rdy, 0);
        wv = 1; wrd = 5'd5;
        #1 chk("raw_bypass", rdy, 1);
        cyc();
        chk("busy5_clr", bsy, 0);
        chk("cnt0", cnt, 0);

        // 3. same-cycle wb and issue to r7: set wins
        issue(5'd7);
        cyc();
        chk("cnt_r7", cnt, 1);
        issue(5'd7);
        #1 chk("waw_stall", rdy, 0);
        wv = 1; wrd = 5'd7;
        #1 chk("waw_bypass", rdy, 1);
        cyc();
        chk("busy7_kept", bsy, 64'h80);
        chk("cnt_same", cnt, 1);
        idle();
        cyc();
        chk("wr7_gone", wr, 0);
        idle(); wv = 1; wrd = 5'd7;
        cyc();
        chk("busy7_clr", bsy, 0);

        // 4. register zero is never busy
        issue(5'd0);
        #1 chk("r0_rdy_a", rdy, 1);
        cyc();
        chk("r0_busy", bsy, 0);
        idle(); iv = 1; irs1_en = 1; irs1 = 0; irs2_en = 1; irs2 = 0;
        #1 chk("r0_rdy_b", rdy, 1);
        wv = 1; wrd = 0;
        cyc();
        chk("r0_cnt", cnt, 0);
        idle();
        cyc();

        // 5. fill every register, then WAW stall on r31
        for (int r = 1; r < 32; r++) begin
            issue(5'(r));
            #1 chk("fill_rdy", rdy, 1);
            cyc();
        end
        chk("fill_cnt", cnt, 31);
        chk("fill_busy", bsy, 64'hFFFF_FFFE);
        issue(5'd31);
        #1 chk("full_waw", rdy, 0);
        cyc();
        chk("full_hold", bsy, 64'hFFFF_FFFE);
        idle(); iv = 1; irs2_en = 1; irs2 = 5'd4;
        #1 chk("full_rs2", rdy, 0);
        irs2_en = 0;
        #1 chk("rs2_unused", rdy, 1);
        idle(); wv = 1; wrd = 5'd31;
        cyc();
        chk("drain_cnt", cnt, 30);
        idle();
        cyc();

        // 6. random traffic on the ADDR_W=3 instance
        m3 = '0;
        for (int n = 0; n < 400; n++) begin
            iv3 = 1'($urandom);
            ird_en3 = 1'($urandom);
            irs1_en3 = 1'($urandom);
            irs2_en3 = 1'($urandom);
            wv3 = 1'($urandom);
            ird3 = 3'($urandom);
            irs13 = 3'($urandom);
            irs23 = 3'($urandom);
            wrd3 = 3'($urandom);
            eb3 = m3;
            if (wv3) eb3[wrd3] = 1'b0;
            eb3[0] = 1'b0;
            er3 = !((irs1_en3 && eb3[irs13]) || (irs2_en3 && eb3[irs23])
                    || (ird_en3 && eb3[ird3]));
            #1 chk("r3_ready", rdy3, er3);
            acc3 = iv3 && er3;
            e3 = '0;
            if (wv3 && wrd3 != 0) e3[wrd3] = 1'b1;
            wrq3.push_back(e3);
            if (wv3) m3[wrd3] = 1'b0;
            rdoh = '0;
            if (acc3 && ird_en3) rdoh[ird3] = 1'b1;
            m3 = (m3 | rdoh) & 8'hFE;
            @(posedge clk);
            #1;
            chk("r3_wr", wr3, wrq3.pop_front());
            chk("r3_onehot", ($countones(wr3) <= 1), 1);
            chk("r3_busy", bsy3, m3);
            chk("r3_cnt", cnt3, 4'($countones(bsy3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
